// File: rtl/rr_arbiter4_pkg.sv
// Shared types, sizes and the round-robin search helper for the rr_arbiter4 slice.
package rr_arbiter4_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // First requester found scanning upward from ptr with wrap; returns ptr when req is empty.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      idx = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (req[cand]) begin
            idx = cand;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface rr_arbiter4_if;
   import rr_arbiter4_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (output req, output done,
                   input gnt, input gnt_idx, input gnt_valid, input timeout);

   modport slave  (input req, input done,
                   output gnt, output gnt_idx, output gnt_valid, output timeout);

endinterface

// File: rtl/rr_dec2to4.sv
// 2-bit index to one-hot decoder with an enable; output is all zero when disabled.
module rr_dec2to4 (
   input  logic [1:0] idx_i,
   input  logic       en_i,
   output logic [3:0] onehot_o
);

   // Decode the index only while the enable is high.
   always_comb begin
      onehot_o = 4'b0000;
      if (en_i) begin
         case (idx_i)
            2'd0:    onehot_o = 4'b0001;
            2'd1:    onehot_o = 4'b0010;
            2'd2:    onehot_o = 4'b0100;
            2'd3:    onehot_o = 4'b1000;
            default: onehot_o = 4'b0000;
         endcase
      end else begin
         onehot_o = 4'b0000;
      end
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a one-cycle idle gap after each release.
// Define RR_ARBITER4_TIMEOUT_EN to force a release after HOLD_MAX busy cycles.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int HOLD_MAX  = 16,
   parameter int RESET_PTR = 0
) (
   input  logic          clk,
   input  logic          rst,
   rr_arbiter4_if.slave  bus
);

   if ((HOLD_MAX < 2) || (HOLD_MAX > 255) || (RESET_PTR < 0) || (RESET_PTR > 3)) begin : g_bad_param
      $error("rr_arbiter4: HOLD_MAX or RESET_PTR out of range");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] pick_s;
   logic             owner_req_s;
   logic             expire_s;
   logic [N_REQ-1:0] gnt_s;

   assign pick_s      = rr_pick(bus.req, ptr_q);
   assign owner_req_s = bus.req[idx_q];

   // Next-state and grant register inputs; done wins over any new request in BUSY.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req != 4'b0000) begin
               state_d = ST_BUSY;
               idx_d   = pick_s;
               valid_d = 1'b1;
               ptr_d   = pick_s + 2'd1;
            end else begin
               valid_d = 1'b0;
            end
         end
         ST_BUSY: begin
            if (bus.done || !owner_req_s || expire_s) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Arbitration state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= IDX_W'(RESET_PTR);
         idx_q   <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

`ifdef RR_ARBITER4_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       timeout_q, timeout_d;

   assign expire_s = (state_q == ST_BUSY) && (hold_cnt_q == HOLD_LAST);

   // Hold counter sits at zero in IDLE so every BUSY entry starts fresh.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      if (state_q == ST_BUSY) begin
         if (bus.done || !owner_req_s) begin
            timeout_d = 1'b0;
         end else if (expire_s) begin
            timeout_d = 1'b1;
         end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
         end
      end else begin
         hold_cnt_d = 8'd0;
      end
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign expire_s    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   rr_dec2to4 u_dec (
      .idx_i    (idx_q),
      .en_i     (valid_q),
      .onehot_o (gnt_s)
   );

   assign bus.gnt       = gnt_s;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: a behavioural owner/priority model queues the
// expected outputs each edge and a negedge monitor compares them against the DUT.
module tb_rr_arbiter4;

   localparam int HOLD      = 4;
   localparam int RST_PTR   = 0;
`ifdef RR_ARBITER4_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       to;
   } exp_t;

   logic clk;
   logic rst;
   rr_arbiter4_if bus ();

   rr_arbiter4 #(.HOLD_MAX(HOLD), .RESET_PTR(RST_PTR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: who owns the resource, whose turn it is, how long held.
   int   owner = -1;
   int   prio  = RST_PTR;
   int   busy_cycles = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      owner       = -1;
      prio        = RST_PTR;
      busy_cycles = 0;
      sb_q.delete();
   endtask

   task automatic model_step(input logic [3:0] r, input logic d);
      exp_t e;
      bit   to;
      to = 1'b0;
      if (owner < 0) begin
         if (r != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (prio + k) % 4;
               if (owner < 0 && r[c]) owner = c;
            end
            prio        = (owner + 1) % 4;
            busy_cycles = 1;
         end
      end else if (d || !r[owner]) begin
         owner = -1;
      end else if (TO_EN && busy_cycles >= HOLD) begin
         owner = -1;
         to    = 1'b1;
      end else begin
         busy_cycles++;
      end
      e.valid = (owner >= 0);
      e.gnt   = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      e.idx   = (owner >= 0) ? 2'(owner) : 2'd0;
      e.to    = to;
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic [3:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
   endtask

   // Asynchronous reset: checked two time units after assertion, with no clock edge in between.
   task automatic do_reset();
      rst      = 1'b1;
      bus.req  = 4'b0000;
      bus.done = 1'b0;
      model_reset();
      #2;
      vectors++;
      if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0 ||
          bus.timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: got gnt=%b idx=%0d valid=%b to=%b, want gnt=0000 idx=0 valid=0 to=0",
                  bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: pop one expectation per cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst && sb_q.size() != 0) begin
         exp_t e;
         bit   ok;
         e  = sb_q.pop_front();
         ok = (bus.gnt === e.gnt) && (bus.gnt_valid === e.valid) &&
              (bus.timeout === e.to) && (!e.valid || bus.gnt_idx === e.idx);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL grant @%0t: got gnt=%b idx=%0d valid=%b to=%b, want gnt=%b idx=%0d valid=%b to=%b",
                     $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
                     e.gnt, e.idx, e.valid, e.to);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      rst      = 1'b1;
      bus.req  = 4'b0000;
      bus.done = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single request, then done.
      cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b1);
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b1);

      // Rotation with all requesters active and done every third cycle.
      do_reset();
      for (int i = 0; i < 15; i++) cycle(4'b1111, (i % 3) == 2);

      // Priority skip from ptr=1 and wrap back to index 0.
      do_reset();
      cycle(4'b0001, 1'b0);
      cycle(4'b0001, 1'b1);
      cycle(4'b1001, 1'b0);
      cycle(4'b1001, 1'b1);
      cycle(4'b1001, 1'b0);
      cycle(4'b1001, 1'b1);

      // Owner drops its request; pending requester follows after the gap.
      do_reset();
      cycle(4'b0110, 1'b0);
      cycle(4'b0110, 1'b0);
      cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b0);

      // Done together with a new request, and done while idle.
      cycle(4'b0101, 1'b1);
      cycle(4'b0101, 1'b1);
      cycle(4'b0101, 1'b0);

      // Long hold of a single requester (forced release when timeouts are built in).
      do_reset();
      for (int i = 0; i < 14; i++) cycle(4'b0001, 1'b0);

      // Asynchronous reset while index 3 owns the resource.
      do_reset();
      cycle(4'b1000, 1'b0);
      cycle(4'b1000, 1'b0);
      do_reset();
      cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b0);

      // Randomised traffic with mostly-stable request levels.
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < 400; i++) begin
         r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         cycle(r, $urandom_range(0, 3) == 0);
         if (i == 200) do_reset();
      end

      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);
      @(negedge clk);
      #1;
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
